// File: rtl/averager_pkg.sv
// averager_pkg: shared FSM states and width helpers for the averaging datapath
package averager_pkg;
   typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, OUTPUT} state_t;
   // Accumulator width that cannot overflow for a maximum-length frame
   function automatic int sum_width(input int nof_bits, input int cnt_bits);
      return nof_bits + cnt_bits;
   endfunction
   // Longest frame the counter can represent
   function automatic int max_len(input int cnt_bits);
      return (1 << cnt_bits) - 1;
   endfunction
endpackage

// File: rtl/frame_averager_if.sv
// frame_averager_if: sample input and result output handshake bundle
//   data_valid/first/last/data_in, in_ready : framed sample stream into the block
//   out_valid/out_ready                     : result handshake toward the consumer
//   sum_out/count_out/avg_out/len_err, busy : result fields and status
//   slave modport = averager side, master modport = source/consumer side
interface frame_averager_if #(parameter int NOF_BITS = 32, parameter int CNT_BITS = 8);
   localparam int SUM_W = averager_pkg::sum_width(NOF_BITS, CNT_BITS);
   logic                data_valid;
   logic                data_first;
   logic                data_last;
   logic [NOF_BITS-1:0] data_in;
   logic                in_ready;
   logic                busy;
   logic                out_valid;
   logic                out_ready;
   logic [SUM_W-1:0]    sum_out;
   logic [CNT_BITS-1:0] count_out;
   logic [NOF_BITS-1:0] avg_out;
   logic                len_err;
   modport slave (
      input  data_valid, data_first, data_last, data_in, out_ready,
      output in_ready, busy, out_valid, sum_out, count_out, avg_out, len_err
   );
   modport master (
      output data_valid, data_first, data_last, data_in, out_ready,
      input  in_ready, busy, out_valid, sum_out, count_out, avg_out, len_err
   );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: restoring unsigned divider, one quotient bit per cycle
//   start             : loads dividend/divisor, clears done
//   dividend, divisor : operands sampled on start
//   done              : high from the final iteration until the next start
//   quotient, remainder : results, held while done
module seq_divider #(
   parameter int DIVIDEND_W = 12,
   parameter int DIVISOR_W  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  done,
   output logic [DIVIDEND_W-1:0] quotient,
   output logic [DIVISOR_W-1:0]  remainder
);
   localparam int CW = $clog2(DIVIDEND_W + 1);
   logic [DIVIDEND_W-1:0] quo_q, quo_d;
   logic [DIVISOR_W-1:0]  rem_q, rem_d, dvs_q, dvs_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  done_q, done_d;
   logic [DIVISOR_W:0]    shifted;
   logic                  ge;
   // quo_q doubles as the dividend shift register: its MSB feeds the partial
   // remainder while the new quotient bit enters at the LSB
   always_comb begin
      shifted = {rem_q, quo_q[DIVIDEND_W-1]};
      ge      = shifted >= {1'b0, dvs_q};
      quo_d   = quo_q;
      rem_d   = rem_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      done_d  = done_q;
      if (start) begin
         quo_d  = dividend;
         rem_d  = '0;
         dvs_d  = divisor;
         cnt_d  = CW'(DIVIDEND_W);
         done_d = 1'b0;
      end else if (cnt_q != '0) begin
         quo_d  = {quo_q[DIVIDEND_W-2:0], ge};
         rem_d  = ge ? DIVISOR_W'(shifted - {1'b0, dvs_q}) : shifted[DIVISOR_W-1:0];
         cnt_d  = cnt_q - CW'(1);
         done_d = cnt_q == CW'(1);
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         quo_q  <= '0;
         rem_q  <= '0;
         dvs_q  <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         quo_q  <= quo_d;
         rem_q  <= rem_d;
         dvs_q  <= dvs_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end
   assign done      = done_q;
   assign quotient  = quo_q;
   assign remainder = rem_q;
endmodule

// File: rtl/frame_averager.sv
// frame_averager: sums one framed burst of samples and reports sum, count and truncated mean
//   clk, rst : clock and asynchronous active-high reset
//   bus      : sample stream in, result handshake out (frame_averager_if slave)
module frame_averager
   import averager_pkg::*;
#(
   parameter int NOF_BITS = 32,
   parameter int CNT_BITS = 8
) (
   input logic              clk,
   input logic              rst,
   frame_averager_if.slave  bus
);
   localparam int SUM_W   = sum_width(NOF_BITS, CNT_BITS);
   localparam int MAX_LEN = max_len(CNT_BITS);
   state_t              state_q, state_d;
   logic [SUM_W-1:0]    sum_q, sum_d;
   logic [CNT_BITS-1:0] count_q, count_d;
   logic [NOF_BITS-1:0] avg_q, avg_d;
   logic                len_err_q, len_err_d;
   logic                in_ready_q, in_ready_d;
   logic                busy_q, busy_d;
   logic                out_valid_q, out_valid_d;
   logic                accept, start, div_done;
   logic [SUM_W-1:0]    quotient;
   logic [CNT_BITS-1:0] remainder;
   logic                unused_div;
   // Divider is loaded on the same edge that accepts the last sample, so it
   // takes the not-yet-registered sum/count of the closing frame
   seq_divider #(.DIVIDEND_W(SUM_W), .DIVISOR_W(CNT_BITS)) u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .dividend  (sum_d),
      .divisor   (count_d),
      .done      (div_done),
      .quotient  (quotient),
      .remainder (remainder)
   );
   // Quotient is bounded by the max sample value, so its upper bits are always zero
   assign unused_div = ^{quotient[SUM_W-1:NOF_BITS], remainder};
   assign accept = bus.data_valid && in_ready_q;
   always_comb begin
      state_d   = state_q;
      sum_d     = sum_q;
      count_d   = count_q;
      avg_d     = avg_q;
      len_err_d = len_err_q;
      start     = 1'b0;
      case (state_q)
         IDLE, ACCUM: begin
            // In IDLE only a first-flagged sample opens a frame; a first in ACCUM restarts it
            if (accept && (bus.data_first || state_q == ACCUM)) begin
               sum_d   = bus.data_first ? SUM_W'(bus.data_in) : sum_q + SUM_W'(bus.data_in);
               count_d = bus.data_first ? CNT_BITS'(1) : count_q + CNT_BITS'(1);
               if (bus.data_last || count_d == CNT_BITS'(MAX_LEN)) begin
                  state_d   = DIVIDE;
                  start     = 1'b1;
                  len_err_d = !bus.data_last;
               end else begin
                  state_d = ACCUM;
               end
            end
         end
         DIVIDE: begin
            if (div_done) begin
               state_d = OUTPUT;
               avg_d   = quotient[NOF_BITS-1:0];
            end
         end
         default: begin
            if (bus.out_ready) begin
               state_d   = IDLE;
               len_err_d = 1'b0;
            end
         end
      endcase
      in_ready_d  = state_d == IDLE || state_d == ACCUM;
      busy_d      = state_d != IDLE;
      out_valid_d = state_d == OUTPUT;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         sum_q       <= '0;
         count_q     <= '0;
         avg_q       <= '0;
         len_err_q   <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sum_q       <= sum_d;
         count_q     <= count_d;
         avg_q       <= avg_d;
         len_err_q   <= len_err_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
         out_valid_q <= out_valid_d;
      end
   end
   assign bus.in_ready  = in_ready_q;
   assign bus.busy      = busy_q;
   assign bus.out_valid = out_valid_q;
   assign bus.sum_out   = sum_q;
   assign bus.count_out = count_q;
   assign bus.avg_out   = avg_q;
   assign bus.len_err   = len_err_q;
endmodule

// File: tb/tb_frame_averager.sv
// tb_frame_averager: directed table-driven checks of frame_averager (NOF_BITS=8, CNT_BITS=4)
module tb_frame_averager;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_pass = 0;
   int   n_total = 0;
   frame_averager_if #(.NOF_BITS(8), .CNT_BITS(4)) bus ();
   frame_averager #(.NOF_BITS(8), .CNT_BITS(4)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   typedef struct {
      int              n;
      logic [2:0][7:0] d;
      logic [2:0]      f;
      logic [2:0]      l;
      logic [11:0]     sum;
      logic [3:0]      cnt;
      logic [7:0]      avg;
   } vec_t;
   vec_t tv[5];
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
      else n_pass++;
   endtask
   task automatic drive(input logic v, input logic f, input logic l, input logic [7:0] d);
      @(negedge clk);
      bus.data_valid = v;
      bus.data_first = f;
      bus.data_last  = l;
      bus.data_in    = d;
   endtask
   task automatic idle();
      @(negedge clk);
      bus.data_valid = 1'b0;
      bus.data_first = 1'b0;
      bus.data_last  = 1'b0;
   endtask
   // Called at the first negedge after the last-sample edge; out_valid must
   // first appear 14 negedges after the drive (edge T+13)
   task automatic wait_result(input string name, input logic [11:0] es, input logic [3:0] ec,
                              input logic [7:0] ea, input logic el);
      int c = 1;
      while (!bus.out_valid && c < 40) begin
         @(negedge clk);
         c++;
      end
      check({name, " latency"}, c, 14);
      check({name, " sum"}, bus.sum_out, es);
      check({name, " count"}, bus.count_out, ec);
      check({name, " avg"}, bus.avg_out, ea);
      check({name, " len_err"}, bus.len_err, el);
   endtask
   task automatic after_handshake(input string name);
      @(negedge clk);
      check({name, " out_valid drop"}, bus.out_valid, 0);
      check({name, " busy drop"}, bus.busy, 0);
      check({name, " in_ready back"}, bus.in_ready, 1);
   endtask
   initial begin
      tv[0] = '{3, {8'd30, 8'd20, 8'd10}, 3'b001, 3'b100, 12'd60, 4'd3, 8'd20};
      tv[1] = '{1, {8'd0, 8'd0, 8'd7}, 3'b001, 3'b001, 12'd7, 4'd1, 8'd7};
      tv[2] = '{3, {8'd9, 8'd5, 8'd100}, 3'b011, 3'b100, 12'd14, 4'd2, 8'd7};
      tv[3] = '{2, {8'd0, 8'd2, 8'd1}, 3'b001, 3'b010, 12'd3, 4'd2, 8'd1};
      tv[4] = '{3, {8'd255, 8'd201, 8'd200}, 3'b001, 3'b100, 12'd656, 4'd3, 8'd218};
      bus.data_valid = 1'b0;
      bus.data_first = 1'b0;
      bus.data_last  = 1'b0;
      bus.data_in    = '0;
      bus.out_ready  = 1'b1;
      #1 rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("reset in_ready", bus.in_ready, 1);
      check("reset busy", bus.busy, 0);
      check("reset out_valid", bus.out_valid, 0);
      check("reset outputs", {bus.sum_out, bus.count_out, bus.avg_out, bus.len_err}, 0);
      drive(1, 0, 1, 8'd50);
      idle();
      check("orphan sample ignored", {bus.busy, bus.count_out}, 0);
      for (int j = 0; j < 15; j++) drive(1, j == 0, 0, 8'd255);
      drive(1, 0, 0, 8'd255);
      check("forced in_ready low", bus.in_ready, 0);
      check("forced busy", bus.busy, 1);
      bus.data_valid = 1'b0;
      wait_result("forced", 12'd3825, 4'd15, 8'd255, 1'b1);
      after_handshake("forced");
      check("forced 16th dropped", bus.count_out, 15);
      for (int i = 0; i < 5; i++) begin
         for (int j = 0; j < tv[i].n; j++) drive(1, tv[i].f[j], tv[i].l[j], tv[i].d[j]);
         idle();
         wait_result($sformatf("vec%0d", i), tv[i].sum, tv[i].cnt, tv[i].avg, 1'b0);
         after_handshake($sformatf("vec%0d", i));
      end
      bus.out_ready = 1'b0;
      drive(1, 1, 0, 8'd50);
      drive(1, 0, 1, 8'd60);
      idle();
      wait_result("bp", 12'd110, 4'd2, 8'd55, 1'b0);
      for (int k = 0; k < 5; k++) begin
         drive(1, 1, 1, 8'd99);
         check("bp out_valid held", bus.out_valid, 1);
         check("bp in_ready low", bus.in_ready, 0);
         check("bp data stable", {bus.sum_out, bus.count_out, bus.avg_out}, {12'd110, 4'd2, 8'd55});
      end
      bus.data_valid = 1'b0;
      bus.out_ready  = 1'b1;
      after_handshake("bp");
      check("bp dropped samples", bus.count_out, 2);
      drive(1, 1, 0, 8'd8);
      drive(1, 0, 1, 8'd9);
      idle();
      repeat (4) @(negedge clk);
      check("pre-reset busy", bus.busy, 1);
      rst = 1'b1;
      #1;
      check("async rst outputs", {bus.sum_out, bus.count_out, bus.avg_out, bus.len_err}, 0);
      check("async rst status", {bus.in_ready, bus.busy, bus.out_valid}, 3'b100);
      @(negedge clk);
      rst = 1'b0;
      drive(1, 1, 0, 8'd3);
      drive(1, 0, 1, 8'd4);
      idle();
      wait_result("post-reset", 12'd7, 4'd2, 8'd3, 1'b0);
      after_handshake("post-reset");
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
